// File: rtl/seq_detect_pkg.sv
// Shared types and helpers for the serial pattern-detect controller.
// Optional feature macro: SEQ_DETECT_CTRL_MATCH_CNT_EN (match counter).
package seq_detect_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        SHIFT = 2'd1,
        DONE  = 2'd2
    } state_t;

    localparam int DEF_WORD_W  = 11;
    localparam int DEF_PAT_MAX = 8;
    localparam int DEF_CNT_W   = 8;

    // Limit a requested length/count to the largest value the datapath supports.
    function automatic int unsigned clamp_len(input int unsigned val, input int unsigned lim);
        return (val > lim) ? lim : val;
    endfunction

endpackage

// File: rtl/pattern_match_core.sv
// Serial pattern-match core: PAT_MAX-bit history, saturating fill counter,
// length-masked compare and overlap/non-overlap restart. Match is registered.
module pattern_match_core
    import seq_detect_pkg::*;
#(
    parameter int PAT_MAX = DEF_PAT_MAX,
    parameter int LEN_W   = $clog2(PAT_MAX + 1)
) (
    input  logic               clk,
    input  logic               reset,
    input  logic               shift_en,
    input  logic               bit_in,
    input  logic               clr,
    input  logic [PAT_MAX-1:0] pattern,
    input  logic [LEN_W-1:0]   len,
    input  logic               overlap,
    output logic               match
);

    logic [PAT_MAX-1:0] hist_q, hist_d, hist_shift, mask;
    logic [LEN_W-1:0]   fill_q, fill_d, fill_inc;
    logic               match_q, match_d, hit;

    // Post-shift history and match evaluation; clear takes priority over a shift.
    always_comb begin
        hist_shift = {hist_q[PAT_MAX-2:0], bit_in};
        fill_inc   = (fill_q == LEN_W'(PAT_MAX)) ? fill_q : fill_q + LEN_W'(1);
        for (int i = 0; i < PAT_MAX; i++) begin
            mask[i] = (LEN_W'(i) < len);
        end
        hit = (len != '0) && (fill_inc >= len) && (((hist_shift ^ pattern) & mask) == '0);

        hist_d  = hist_q;
        fill_d  = fill_q;
        match_d = 1'b0;
        if (clr) begin
            hist_d = '0;
            fill_d = '0;
        end else if (shift_en) begin
            hist_d  = hist_shift;
            fill_d  = (hit && !overlap) ? '0 : fill_inc;
            match_d = hit;
        end
    end

    // History, fill and registered match pulse.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            hist_q  <= '0;
            fill_q  <= '0;
            match_q <= 1'b0;
        end else begin
            hist_q  <= hist_d;
            fill_q  <= fill_d;
            match_q <= match_d;
        end
    end

    assign match = match_q;

endmodule

// File: rtl/seq_detect_ctrl.sv
// Streaming controller: valid/ready word intake, LSB-first serializer into
// pattern_match_core, end-of-word pulse. Optional saturating match counter
// enabled by defining SEQ_DETECT_CTRL_MATCH_CNT_EN.
module seq_detect_ctrl
    import seq_detect_pkg::*;
#(
    parameter int WORD_W  = DEF_WORD_W,
    parameter int PAT_MAX = DEF_PAT_MAX,
    parameter int CNT_W   = DEF_CNT_W
) (
    input  logic                           clk,
    input  logic                           reset,
    input  logic                           in_valid,
    output logic                           in_ready,
    input  logic [WORD_W-1:0]              in_word,
    input  logic [$clog2(WORD_W+1)-1:0]    in_nbits,
    input  logic [PAT_MAX-1:0]             cfg_pattern,
    input  logic [$clog2(PAT_MAX+1)-1:0]   cfg_len,
    input  logic                           cfg_overlap,
    input  logic                           flush,
    output logic                           out,
    output logic                           busy,
    output logic                           done
`ifdef SEQ_DETECT_CTRL_MATCH_CNT_EN
    ,
    input  logic                           clr_count,
    output logic [CNT_W-1:0]               match_count
`endif
);

    localparam int NB_W  = $clog2(WORD_W + 1);
    localparam int LEN_W = $clog2(PAT_MAX + 1);

    state_t             state_q, state_d;
    logic [WORD_W-1:0]  word_q, word_d;
    logic [NB_W-1:0]    nbits_q, nbits_d, nbits_clamped;
    logic [NB_W-1:0]    idx_q, idx_d;
    logic [PAT_MAX-1:0] pat_q, pat_d;
    logic [LEN_W-1:0]   len_q, len_d;
    logic               ovl_q, ovl_d;
    logic               accept, last_bit, shift_en, core_clr, bit_in;

    // Handshake qualifiers and serializer tap.
    always_comb begin
        accept        = (state_q == IDLE) && in_valid;
        nbits_clamped = NB_W'(clamp_len(32'(in_nbits), WORD_W));
        last_bit      = (idx_q == nbits_q - NB_W'(1));
        shift_en      = (state_q == SHIFT);
        core_clr      = (state_q == IDLE) && flush;
        bit_in        = word_q[idx_q];
    end

    // State register.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) state_q <= IDLE;
        else        state_q <= state_d;
    end

    // Next-state logic.
    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE:    if (accept) state_d = (nbits_clamped == '0) ? DONE : SHIFT;
            SHIFT:   if (last_bit) state_d = DONE;
            DONE:    state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    // Moore outputs decoded from the registered state.
    always_comb begin
        in_ready = (state_q == IDLE);
        busy     = (state_q != IDLE);
        done     = (state_q == DONE);
    end

    // Word/config snapshot on accept and bit index advance while shifting.
    always_comb begin
        word_d  = word_q;
        nbits_d = nbits_q;
        idx_d   = idx_q;
        pat_d   = pat_q;
        len_d   = len_q;
        ovl_d   = ovl_q;
        if (accept) begin
            word_d  = in_word;
            nbits_d = nbits_clamped;
            idx_d   = '0;
            pat_d   = cfg_pattern;
            len_d   = LEN_W'(clamp_len(32'(cfg_len), PAT_MAX));
            ovl_d   = cfg_overlap;
        end else if (shift_en) begin
            idx_d = idx_q + NB_W'(1);
        end
    end

    // Snapshot registers.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            word_q  <= '0;
            nbits_q <= '0;
            idx_q   <= '0;
            pat_q   <= '0;
            len_q   <= '0;
            ovl_q   <= 1'b0;
        end else begin
            word_q  <= word_d;
            nbits_q <= nbits_d;
            idx_q   <= idx_d;
            pat_q   <= pat_d;
            len_q   <= len_d;
            ovl_q   <= ovl_d;
        end
    end

    pattern_match_core #(
        .PAT_MAX (PAT_MAX),
        .LEN_W   (LEN_W)
    ) u_core (
        .clk      (clk),
        .reset    (reset),
        .shift_en (shift_en),
        .bit_in   (bit_in),
        .clr      (core_clr),
        .pattern  (pat_q),
        .len      (len_q),
        .overlap  (ovl_q),
        .match    (out)
    );

`ifdef SEQ_DETECT_CTRL_MATCH_CNT_EN
    logic [CNT_W-1:0] cnt_q, cnt_d;

    // Saturating count of match pulses; clear beats a coincident match.
    always_comb begin
        cnt_d = cnt_q;
        if (clr_count)                cnt_d = '0;
        else if (out && cnt_q != '1)  cnt_d = cnt_q + CNT_W'(1);
    end

    // Match counter register.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) cnt_q <= '0;
        else        cnt_q <= cnt_d;
    end

    assign match_count = cnt_q;
`endif

endmodule
